pixel_mode_pipe: RTL
====================

PIXEL_MODE_PIPE -- requirements
Module: pixel_mode_pipe

Interface
REQ-001 Parameter CH_W, default 8, bits per colour channel; RGB_W = 3*CH_W.
REQ-002 Parameter FRAME_PIXELS, default 1024, pixels per frame; CNT_W = $clog2(FRAME_PIXELS+1).
REQ-003 Clocking SHALL be one clock with synchronous, active-high reset:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous active-high reset.
REQ-004 Control ports:
- mode_i  in  3  requested mode, sampled at frame start.
- thresh_i  in  CH_W  threshold, sampled at frame start.
- frame_start_i  in  1  frame start request.
REQ-005 Input stream ports:
- in_valid_i  in  1  input pixel valid.
- in_ready_o  out  1  block accepts input.
- in_pixel_i  in  RGB_W  {R,G,B}, R in MSBs.
REQ-006 Output stream ports:
- out_valid_o  out  1  output pixel valid.
- out_ready_i  in  1  sink accepts output.
- out_pixel_o  out  RGB_W  processed pixel.
- out_last_o  out  1  final pixel of frame.
REQ-007 Status ports:
- busy_o  out  1  state not IDLE.
- frame_done_o  out  1  one-cycle frame completion pulse.
- mode_err_o  out  1  one-cycle illegal-mode pulse.

Function
REQ-008 Modes: 000 GRAY, 001 BYPASS, 010 THRESH, 011 INVERT; 1xx illegal.
REQ-009 FSM states: IDLE, RUN, DRAIN.
REQ-010 IDLE with frame_start_i=1 and legal mode: latch mode_i and thresh_i, clear pixel counter, go to RUN next cycle.
REQ-011 IDLE with frame_start_i=1 and illegal mode: pulse mode_err_o for one cycle and stay in IDLE.
REQ-012 frame_start_i outside IDLE SHALL be ignored; latched mode and threshold stay constant for the whole frame.
REQ-013 Input handshake occurs when in_valid_i && in_ready_o.
REQ-014 in_ready_o = (state==RUN) && pipeline enable && (count < FRAME_PIXELS).
REQ-015 count increments on each input handshake; the handshake that makes count reach FRAME_PIXELS moves the FSM to DRAIN.
REQ-016 Two-stage pipeline; both stages advance on enable = !out_valid_o || out_ready_i.
REQ-017 Stage 1 SHALL compute sum = R + 2G + B at CH_W+2 bits, with no overflow.
REQ-018 Stage 2: gray = sum[CH_W+1:2] (truncating divide by 4). Stage 2 registers out_pixel_o as:
- GRAY: gray zero-extended to RGB_W.
- BYPASS: the input pixel unchanged, delayed alongside.
- THRESH: zero-extended (gray >= thresh ? all-ones CH_W : 0).
- INVERT: zero-extended ~gray.
REQ-019 Latency SHALL be 2 cycles from input handshake to out_valid_o when out_ready_i=1; throughput 1 pixel/cycle.
REQ-020 With out_ready_i=0 and out_valid_o=1, out_pixel_o and out_last_o SHALL hold; no pixel is lost, duplicated or reordered.
REQ-021 out_last_o SHALL be high only with the pixel from the FRAME_PIXELS-th input handshake.
REQ-022 In DRAIN, after the out_last_o output handshake: pulse frame_done_o the next cycle and return to IDLE that same cycle.
REQ-023 A frame_start_i in the same cycle as frame_done_o SHALL be ignored.

Reset
REQ-024 reset_i=1 at a clock edge SHALL force, from the next cycle, regardless of activity:
- FSM to IDLE, count to 0.
- All pipeline valid bits and data to 0.
- in_ready_o, out_valid_o, out_last_o, busy_o, frame_done_o, mode_err_o to 0.
- out_pixel_o to 0.
REQ-025 Reset mid-frame SHALL discard in-flight pixels without emitting them.

Structure
REQ-026 A shared package SHALL hold the mode enum (mode_t, 3 bits), the state enum (state_t), and default CH_W and FRAME_PIXELS.
REQ-027 One sub-module, pixel_gray_stage, SHALL hold the sum/shift arithmetic; control and FSM stay in pixel_mode_pipe.

Verification
REQ-028 Bench SHALL use CH_W=8, FRAME_PIXELS=4 and cover these directed scenarios:
- GRAY, pixel 0x408020, out_ready=1 -> out_pixel 0x000058 exactly 2 cycles after handshake.
- THRESH, same pixel: thresh 0x58 -> 0x0000FF; thresh 0x59 -> 0x000000. INVERT -> 0x0000A7.
- BYPASS, 4 pixels, out_ready low for 3 cycles mid-stream -> in_ready_o drops; outputs arrive in order, unchanged, none duplicated.
- 4-pixel frame -> out_last_o only on pixel 4; frame_done_o one cycle after its handshake; 5th in_valid not accepted.
- frame_start with mode 101 -> mode_err_o single pulse, busy_o=0, in_ready_o=0.
- reset_i asserted after 2 pixels accepted -> next cycle all outputs 0, state IDLE, no further outputs.

Source files
------------

// File: rtl/pixel_mode_pipe_pkg.sv
// Shared types and defaults for the pixel mode pipeline.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pixel_mode_pipe_pkg;

  localparam int DEF_CH_W         = 8;
  localparam int DEF_FRAME_PIXELS = 1024;

  // Per-frame processing mode. Any code with bit 2 set is illegal.
  typedef enum logic [2:0] {
    MODE_GRAY   = 3'b000,
    MODE_BYPASS = 3'b001,
    MODE_THRESH = 3'b010,
    MODE_INVERT = 3'b011
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic mode_legal(input logic [2:0] m);
    return !m[2];
  endfunction

endpackage

// File: rtl/pixel_gray_stage.sv
// Luma arithmetic: sum = R + 2G + B, and gray = sum / 4 (truncating).
// Latency: purely combinational; the caller owns the pipeline registers.
// Backpressure: none, the caller gates its registers.
// Ports:
//   pixel_i : {R,G,B} input pixel, R in the MSBs
//   sum_o   : R + 2G + B at CH_W+2 bits (cannot overflow)
//   sum_i   : registered sum from the first pipeline stage
//   gray_o  : sum_i >> 2, CH_W bits
module pixel_gray_stage #(
  parameter int CH_W = 8
) (
  input  logic [3*CH_W-1:0] pixel_i,
  output logic [CH_W+1:0]   sum_o,
  input  logic [CH_W+1:0]   sum_i,
  output logic [CH_W-1:0]   gray_o
);

  logic [CH_W-1:0] r, g, b;

  assign r = pixel_i[3*CH_W-1:2*CH_W];
  assign g = pixel_i[2*CH_W-1:CH_W];
  assign b = pixel_i[CH_W-1:0];

  // Max value is 4*(2^CH_W - 1), which fits in CH_W+2 bits.
  assign sum_o  = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
  assign gray_o = CH_W'(sum_i >> 2);

endmodule

// File: rtl/pixel_mode_pipe.sv
// Frame-based pixel processor: GRAY / BYPASS / THRESH / INVERT per frame.
// Latency: 2 cycles from input handshake to out_valid_o, 1 pixel/cycle.
// Backpressure: both stages stall on out_valid_o && !out_ready_i; in_ready_o drops.
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset
//   mode_i, thresh_i         : frame configuration, sampled on accepted frame start
//   frame_start_i            : frame start request (honoured only in IDLE)
//   in_valid_i/in_ready_o/in_pixel_i              : input stream
//   out_valid_o/out_ready_i/out_pixel_o/out_last_o : output stream
//   busy_o, frame_done_o, mode_err_o               : status
module pixel_mode_pipe
  import pixel_mode_pipe_pkg::*;
#(
  parameter  int CH_W         = DEF_CH_W,
  parameter  int FRAME_PIXELS = DEF_FRAME_PIXELS,
  localparam int RGB_W        = 3 * CH_W,
  localparam int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [2:0]       mode_i,
  input  logic [CH_W-1:0]  thresh_i,
  input  logic             frame_start_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [RGB_W-1:0] in_pixel_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [RGB_W-1:0] out_pixel_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             mode_err_o
);

  localparam logic [CNT_W-1:0] FP_CNT  = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] FP_LAST = CNT_W'(FRAME_PIXELS - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  count_q;
  mode_t             mode_q;
  logic [CH_W-1:0]   thresh_q;
  logic              frame_done_q;
  logic              mode_err_q;

  logic              s1_vld_q;
  logic              s1_last_q;
  logic [CH_W+1:0]   s1_sum_q;
  logic [RGB_W-1:0]  s1_pix_q;
  logic              out_vld_q;
  logic              out_last_q;
  logic [RGB_W-1:0]  out_pix_q;

  logic              pipe_en;
  logic              in_hs;
  logic              out_hs;
  logic [CH_W+1:0]   sum_d;
  logic [CH_W-1:0]   gray;
  logic [RGB_W-1:0]  out_pix_d;

  pixel_gray_stage #(.CH_W(CH_W)) u_gray (
    .pixel_i (in_pixel_i),
    .sum_o   (sum_d),
    .sum_i   (s1_sum_q),
    .gray_o  (gray)
  );

  assign pipe_en    = !out_vld_q || out_ready_i;
  assign in_ready_o = (state_q == ST_RUN) && pipe_en && (count_q < FP_CNT);
  assign in_hs      = in_valid_i && in_ready_o;
  assign out_hs     = out_vld_q && out_ready_i;

  assign out_valid_o  = out_vld_q;
  assign out_pixel_o  = out_pix_q;
  assign out_last_o   = out_last_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;
  assign mode_err_o   = mode_err_q;

  // Stage-2 result selection; mode_q is frozen for the whole frame.
  always_comb begin
    out_pix_d = '0;
    case (mode_q)
      MODE_GRAY:   out_pix_d = {{(RGB_W-CH_W){1'b0}}, gray};
      MODE_BYPASS: out_pix_d = s1_pix_q;
      MODE_THRESH: out_pix_d = {{(RGB_W-CH_W){1'b0}},
                                (gray >= thresh_q) ? {CH_W{1'b1}} : {CH_W{1'b0}}};
      MODE_INVERT: out_pix_d = {{(RGB_W-CH_W){1'b0}}, ~gray};
      default:     out_pix_d = '0;
    endcase
  end

  // Two-stage pipeline. Data registers only load with a valid beat so the
  // held output pixel stays stable across bubbles and stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_vld_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_sum_q   <= '0;
      s1_pix_q   <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_pix_q  <= '0;
    end else if (pipe_en) begin
      s1_vld_q   <= in_hs;
      s1_last_q  <= in_hs && (count_q == FP_LAST);
      if (in_hs) begin
        s1_sum_q <= sum_d;
        s1_pix_q <= in_pixel_i;
      end
      out_vld_q  <= s1_vld_q;
      out_last_q <= s1_vld_q && s1_last_q;
      if (s1_vld_q) begin
        out_pix_q <= out_pix_d;
      end
    end
  end

  // Frame control FSM with registered status pulses.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      mode_q       <= MODE_GRAY;
      thresh_q     <= '0;
      frame_done_q <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      mode_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // The completion-pulse cycle is already IDLE, but a start
          // arriving alongside frame_done_o is deliberately dropped.
          if (frame_start_i && !frame_done_q) begin
            if (mode_legal(mode_i)) begin
              mode_q   <= mode_t'(mode_i);
              thresh_q <= thresh_i;
              count_q  <= '0;
              state_q  <= ST_RUN;
            end else begin
              mode_err_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (in_hs) begin
            count_q <= count_q + 1'b1;
            if (count_q == FP_LAST) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_hs && out_last_q) begin
            frame_done_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
